// File: rtl/mcsr_file_if.sv
// rtl/mcsr_file_if.sv - execution-unit to machine CSR file bus
//
// Purpose: bundles the exu2csr_* request/trap signals and csr2exu_* responses.
// Ports (signals):
//   exu2csr_r_req, exu2csr_w_req, exu2csr_rw_addr, exu2csr_w_cmd, exu2csr_w_data
//   exu2csr_take_irq, exu2csr_take_exc, exu2csr_exc_code, exu2csr_trap_val
//   exu2csr_mret_instr, exu2csr_mret_update, curr_pc, next_pc, retire_cnt
//   csr2exu_r_data, csr2exu_rw_exc, csr2exu_irq, csr2exu_new_pc
// Modports: master = execution unit, slave = CSR file.
interface mcsr_file_if;
  logic        exu2csr_r_req;
  logic        exu2csr_w_req;
  logic [11:0] exu2csr_rw_addr;
  logic [1:0]  exu2csr_w_cmd;
  logic [31:0] exu2csr_w_data;
  logic        exu2csr_take_irq;
  logic        exu2csr_take_exc;
  logic [3:0]  exu2csr_exc_code;
  logic [31:0] exu2csr_trap_val;
  logic        exu2csr_mret_instr;
  logic        exu2csr_mret_update;
  logic [31:0] curr_pc;
  logic [31:0] next_pc;
  logic [2:0]  retire_cnt;
  logic [31:0] csr2exu_r_data;
  logic        csr2exu_rw_exc;
  logic        csr2exu_irq;
  logic [31:0] csr2exu_new_pc;

  modport master (
    output exu2csr_r_req, exu2csr_w_req, exu2csr_rw_addr, exu2csr_w_cmd, exu2csr_w_data,
    output exu2csr_take_irq, exu2csr_take_exc, exu2csr_exc_code, exu2csr_trap_val,
    output exu2csr_mret_instr, exu2csr_mret_update, curr_pc, next_pc, retire_cnt,
    input  csr2exu_r_data, csr2exu_rw_exc, csr2exu_irq, csr2exu_new_pc
  );

  modport slave (
    input  exu2csr_r_req, exu2csr_w_req, exu2csr_rw_addr, exu2csr_w_cmd, exu2csr_w_data,
    input  exu2csr_take_irq, exu2csr_take_exc, exu2csr_exc_code, exu2csr_trap_val,
    input  exu2csr_mret_instr, exu2csr_mret_update, curr_pc, next_pc, retire_cnt,
    output csr2exu_r_data, csr2exu_rw_exc, csr2exu_irq, csr2exu_new_pc
  );
endinterface

// File: rtl/mcsr_file.sv
// rtl/mcsr_file.sv - machine-mode CSR file with trap state, interrupts and counters
//
// Purpose: serves CSR read/write/set/clear, records trap state, supplies the
// trap/return target PC, prioritises interrupts, runs mcycle/minstret.
// Ports:
//   clk                      clock
//   rst                      synchronous active-low reset
//   ext_irq, tmr_irq, sw_irq raw interrupt lines
//   exu                      mcsr_file_if.slave bus to the execution unit
module mcsr_file #(
  parameter logic [31:0] MTVEC_RST = 32'h100,
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_irq,
  input  logic       tmr_irq,
  input  logic       sw_irq,
  mcsr_file_if.slave exu
);

  logic        mst_mie, mst_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
  logic [63:0] mcycle_q, minstret_q;

  logic [31:0] rdata, wval, base, pend;
  logic        hit, rw_exc, w_en;
  logic [3:0]  irq_code;
  logic [63:0] cyc_sum, ins_sum;
  logic [11:0] addr;

  assign addr = exu.exu2csr_rw_addr;

  always_comb begin
    rdata = 32'h0;
    hit   = 1'b1;
    case (addr)
      12'hF11, 12'hF12, 12'hF13: rdata = 32'h0;
      12'hF14: rdata = HART_ID;
      12'h300: rdata = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
      12'h301: rdata = MISA_VAL;
      12'h304: rdata = mie_q;
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'h344: rdata = mip_q;
      12'hB00, 12'hC00: rdata = mcycle_q[31:0];
      12'hB80, 12'hC80: rdata = mcycle_q[63:32];
      12'hB02, 12'hC02: rdata = minstret_q[31:0];
      12'hB82, 12'hC82: rdata = minstret_q[63:32];
      default: hit = 1'b0;
    endcase
  end

  // Addresses with [11:10]==11 are read-only by encoding.
  assign rw_exc = (exu.exu2csr_r_req | exu.exu2csr_w_req) &
                  (~hit | (exu.exu2csr_w_req & (addr[11:10] == 2'b11)));

  always_comb begin
    case (exu.exu2csr_w_cmd)
      2'b01:   wval = exu.exu2csr_w_data;
      2'b10:   wval = rdata | exu.exu2csr_w_data;
      2'b11:   wval = rdata & ~exu.exu2csr_w_data;
      default: wval = rdata;
    endcase
  end

  // Traps pre-empt software writes issued in the same cycle.
  assign w_en = exu.exu2csr_w_req & ~rw_exc & ~exu.exu2csr_take_exc &
                ~exu.exu2csr_take_irq & (exu.exu2csr_w_cmd != 2'b00);

  assign pend = mip_q & mie_q;

  always_comb begin
    if (pend[11])     irq_code = 4'd11;
    else if (pend[3]) irq_code = 4'd3;
    else if (pend[7]) irq_code = 4'd7;
    else              irq_code = 4'd0;
  end

  assign base = {mtvec_q[31:2], 2'b00};

  always_comb begin
    if (exu.exu2csr_take_exc)
      exu.csr2exu_new_pc = base;
    else if (exu.exu2csr_take_irq)
      exu.csr2exu_new_pc = mtvec_q[0] ? base + {26'b0, irq_code, 2'b00} : base;
    else if (exu.exu2csr_mret_instr)
      exu.csr2exu_new_pc = mepc_q;
    else
      exu.csr2exu_new_pc = base;
  end

  assign exu.csr2exu_r_data = rdata;
  assign exu.csr2exu_rw_exc = rw_exc;
  assign exu.csr2exu_irq    = mst_mie & (|pend);

  assign cyc_sum = mcycle_q + 64'd1;
  assign ins_sum = minstret_q + {61'b0, exu.retire_cnt};

  always_ff @(posedge clk) begin
    if (!rst) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= 32'h0;
      mip_q      <= 32'h0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mip_q      <= {20'b0, ext_irq, 3'b0, tmr_irq, 3'b0, sw_irq, 3'b0};
      mcycle_q   <= cyc_sum;
      minstret_q <= ins_sum;
      // A written counter half overrides the increment; the other half
      // still takes the incremented value.
      if (w_en) begin
        case (addr)
          12'h300: begin
            mst_mie  <= wval[3];
            mst_mpie <= wval[7];
          end
          12'h304: mie_q      <= wval & 32'h0000_0888;
          12'h305: mtvec_q    <= {wval[31:2], 1'b0, wval[0]};
          12'h340: mscratch_q <= wval;
          12'h341: mepc_q     <= {wval[31:1], 1'b0};
          12'h342: mcause_q   <= wval;
          12'h343: mtval_q    <= wval;
          12'hB00: mcycle_q[31:0]    <= wval;
          12'hB80: mcycle_q[63:32]   <= wval;
          12'hB02: minstret_q[31:0]  <= wval;
          12'hB82: minstret_q[63:32] <= wval;
          default: ;
        endcase
      end
      if (exu.exu2csr_take_exc) begin
        mepc_q   <= {exu.curr_pc[31:1], 1'b0};
        mcause_q <= {1'b0, 27'b0, exu.exu2csr_exc_code};
        mtval_q  <= exu.exu2csr_trap_val;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (exu.exu2csr_take_irq) begin
        mepc_q   <= {exu.next_pc[31:1], 1'b0};
        mcause_q <= {1'b1, 27'b0, irq_code};
        mtval_q  <= 32'h0;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (exu.exu2csr_mret_update) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mcsr_file.sv
// tb/tb_mcsr_file.sv - directed self-checking bench for mcsr_file
module tb_mcsr_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ext_irq = 1'b0, tmr_irq = 1'b0, sw_irq = 1'b0;
  int checks = 0;
  int errors = 0;

  mcsr_file_if bus ();

  mcsr_file dut (
    .clk     (clk),
    .rst     (rst),
    .ext_irq (ext_irq),
    .tmr_irq (tmr_irq),
    .sw_irq  (sw_irq),
    .exu     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    bus.exu2csr_rw_addr = a;
    bus.exu2csr_r_req   = 1'b1;
    #1;
    chk(tag, bus.csr2exu_r_data, exp);
    bus.exu2csr_r_req   = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] cmd, input logic [31:0] d);
    bus.exu2csr_rw_addr = a;
    bus.exu2csr_w_cmd   = cmd;
    bus.exu2csr_w_data  = d;
    bus.exu2csr_w_req   = 1'b1;
    tick();
    bus.exu2csr_w_req   = 1'b0;
  endtask

  task automatic take_irq_chk(input logic [31:0] exp_pc, input logic [31:0] exp_cause, input string tag);
    bus.exu2csr_take_irq = 1'b1;
    bus.next_pc          = 32'h1234;
    #1;
    chk({tag, "_pc"}, bus.csr2exu_new_pc, exp_pc);
    tick();
    bus.exu2csr_take_irq = 1'b0;
    rd(12'h342, exp_cause, {tag, "_cause"});
  endtask

  initial begin
    bus.exu2csr_r_req = 0; bus.exu2csr_w_req = 0; bus.exu2csr_rw_addr = 12'h300;
    bus.exu2csr_w_cmd = 0; bus.exu2csr_w_data = 0; bus.exu2csr_take_irq = 0;
    bus.exu2csr_take_exc = 0; bus.exu2csr_exc_code = 0; bus.exu2csr_trap_val = 0;
    bus.exu2csr_mret_instr = 0; bus.exu2csr_mret_update = 0;
    bus.curr_pc = 0; bus.next_pc = 0; bus.retire_cnt = 0;

    tick(); tick();
    rst = 1'b1;
    chk("rst_irq", {31'b0, bus.csr2exu_irq}, 32'h0);
    chk("rst_exc", {31'b0, bus.csr2exu_rw_exc}, 32'h0);
    chk("rst_newpc", bus.csr2exu_new_pc, 32'h100);
    rd(12'hF14, 32'h0, "mhartid");
    rd(12'h301, 32'h4000_0100, "misa");
    rd(12'h305, 32'h100, "mtvec_rst");
    rd(12'h300, 32'h1800, "mstatus_rst");

    // write to read-only mhartid
    bus.exu2csr_rw_addr = 12'hF14; bus.exu2csr_w_cmd = 2'b01;
    bus.exu2csr_w_data = 32'h5; bus.exu2csr_w_req = 1'b1;
    #1 chk("ro_wr_exc", {31'b0, bus.csr2exu_rw_exc}, 32'h1);
    tick();
    bus.exu2csr_w_req = 1'b0;
    rd(12'hF14, 32'h0, "mhartid_kept");

    bus.exu2csr_rw_addr = 12'h7C0; bus.exu2csr_r_req = 1'b1;
    #1 chk("unimpl_exc", {31'b0, bus.csr2exu_rw_exc}, 32'h1);
    bus.exu2csr_r_req = 1'b0;

    // mscratch write/set/clear/no-op
    wr(12'h340, 2'b01, 32'hA5A5_0000);
    wr(12'h340, 2'b10, 32'h0000_000F);
    wr(12'h340, 2'b11, 32'h0500_0000);
    rd(12'h340, 32'hA0A5_000F, "mscratch_wsc");
    wr(12'h340, 2'b00, 32'hFFFF_FFFF);
    rd(12'h340, 32'hA0A5_000F, "mscratch_nop");

    // interrupt setup
    wr(12'h305, 2'b01, 32'h203);
    rd(12'h305, 32'h201, "mtvec_bit1");
    wr(12'h304, 2'b01, 32'hFFFF_FFFF);
    rd(12'h304, 32'h888, "mie_mask");
    wr(12'h304, 2'b01, 32'h800);
    wr(12'h300, 2'b01, 32'h8);
    rd(12'h300, 32'h1808, "mstatus_mie");
    ext_irq = 1'b1;
    #1 chk("irq_before", {31'b0, bus.csr2exu_irq}, 32'h0);
    tick();
    chk("irq_after", {31'b0, bus.csr2exu_irq}, 32'h1);
    rd(12'h344, 32'h800, "mip_ext");
    take_irq_chk(32'h22C, 32'h8000_000B, "irq_ext");
    ext_irq = 1'b0;
    rd(12'h341, 32'h1234, "mepc_irq");
    rd(12'h343, 32'h0, "mtval_irq");
    rd(12'h300, 32'h1880, "mstatus_irq");
    chk("irq_masked", {31'b0, bus.csr2exu_irq}, 32'h0);

    // exception with a colliding mscratch write, then mret
    wr(12'h300, 2'b01, 32'h8);
    chk("irq_dropped", {31'b0, bus.csr2exu_irq}, 32'h0);
    bus.exu2csr_take_exc = 1'b1; bus.exu2csr_exc_code = 4'd2;
    bus.exu2csr_trap_val = 32'hDEAD; bus.curr_pc = 32'h300;
    bus.exu2csr_rw_addr = 12'h340; bus.exu2csr_w_cmd = 2'b01;
    bus.exu2csr_w_data = 32'h1234_5678; bus.exu2csr_w_req = 1'b1;
    #1 chk("exc_pc", bus.csr2exu_new_pc, 32'h200);
    tick();
    bus.exu2csr_take_exc = 1'b0; bus.exu2csr_w_req = 1'b0;
    rd(12'h342, 32'h2, "exc_cause");
    rd(12'h343, 32'hDEAD, "exc_mtval");
    rd(12'h341, 32'h300, "exc_mepc");
    rd(12'h340, 32'hA0A5_000F, "exc_scratch");
    rd(12'h300, 32'h1880, "exc_mstatus");
    bus.exu2csr_mret_instr = 1'b1; bus.exu2csr_mret_update = 1'b1;
    #1 chk("mret_pc", bus.csr2exu_new_pc, 32'h300);
    tick();
    bus.exu2csr_mret_instr = 1'b0; bus.exu2csr_mret_update = 1'b0;
    rd(12'h300, 32'h1888, "mret_mstatus");

    // counters
    wr(12'hB80, 2'b01, 32'h0);
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_set");
    rd(12'hC80, 32'h0, "cycleh_pre");
    tick();
    rd(12'hB80, 32'h1, "mcycleh_carry");
    rd(12'hB00, 32'h0, "mcycle_wrap");
    rd(12'hC80, 32'h1, "cycleh_shadow");
    rd(12'hB02, 32'h0, "minstret_0");
    bus.retire_cnt = 3'd4;
    tick(); tick(); tick();
    bus.retire_cnt = 3'd0;
    rd(12'hB02, 32'd12, "minstret_12");
    rd(12'hC02, 32'd12, "instret_shadow");
    rd(12'hB82, 32'h0, "minstreth");
    bus.exu2csr_rw_addr = 12'hC00; bus.exu2csr_w_cmd = 2'b01; bus.exu2csr_w_req = 1'b1;
    #1 chk("shadow_wr_exc", {31'b0, bus.csr2exu_rw_exc}, 32'h1);
    bus.exu2csr_w_req = 1'b0;

    // interrupt priority
    wr(12'h304, 2'b01, 32'h888);
    wr(12'h300, 2'b01, 32'h8);
    ext_irq = 1'b1; tmr_irq = 1'b1; sw_irq = 1'b1;
    tick();
    chk("irq_all", {31'b0, bus.csr2exu_irq}, 32'h1);
    take_irq_chk(32'h22C, 32'h8000_000B, "prio_ext");
    ext_irq = 1'b0;
    wr(12'h300, 2'b01, 32'h8);
    take_irq_chk(32'h20C, 32'h8000_0003, "prio_sw");
    sw_irq = 1'b0;
    wr(12'h300, 2'b01, 32'h8);
    take_irq_chk(32'h21C, 32'h8000_0007, "prio_tmr");
    tmr_irq = 1'b0;

    // reset in the same cycle as a trap
    bus.exu2csr_take_exc = 1'b1; bus.exu2csr_exc_code = 4'd5; bus.curr_pc = 32'h444;
    rst = 1'b0;
    tick();
    rst = 1'b1; bus.exu2csr_take_exc = 1'b0;
    rd(12'h342, 32'h0, "rst_trap_cause");
    rd(12'h341, 32'h0, "rst_trap_mepc");
    rd(12'h305, 32'h100, "rst_trap_mtvec");
    chk("rst_trap_newpc", bus.csr2exu_new_pc, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
